imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 196 +++++++++++++++++++
 tb/tb_imem_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-stream loader: length-prefixed byte stream into instruction memory.
// Optional trailing checksum word enabled by `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [15:0]       words_loaded,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              core_rst_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       words_q, words_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    logic        acc;
    logic [31:0] word;
    logic [15:0] len_full;
    logic [23:0] asm_ins;
    logic        last_word;

    assign busy = (state_q == S_LEN_LO) || (state_q == S_LEN_HI)
`ifdef IMEM_LOADER_CHECKSUM_EN
               || (state_q == S_CSUM)
`endif
               || (state_q == S_DATA);

    assign in_ready     = busy;
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign core_rst_n   = (state_q == S_DONE);
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;

    assign acc       = in_valid && in_ready;
    assign word      = {in_byte, asm_q};
    assign len_full  = {in_byte, len_q[7:0]};
    assign last_word = (words_q + 16'd1) == len_q;

    // Byte lanes 0..2 are buffered; lane 3 arrives with the completing handshake.
    always_comb begin
        asm_ins = asm_q;
        unique case (bcnt_q)
            2'd0:    asm_ins[7:0]   = in_byte;
            2'd1:    asm_ins[15:8]  = in_byte;
            2'd2:    asm_ins[23:16] = in_byte;
            default: asm_ins = asm_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    len_d   = '0;
                    words_d = '0;
                    bcnt_d  = '0;
                    asm_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN_LO: begin
                if (acc) begin
                    len_d[7:0] = in_byte;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (acc) begin
                    len_d = len_full;
                    if (len_full > 16'(DEPTH)) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (acc) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        wdata_d = word;
                        words_d = words_q + 16'd1;
                        asm_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d  = csum_q + word;
                        if (last_word) state_d = S_CSUM;
`else
                        if (last_word) state_d = S_DONE;
`endif
                    end else begin
                        asm_d = asm_ins;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (acc) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        asm_d   = '0;
                        state_d = (word == csum_q) ? S_DONE : S_ERR;
                    end else begin
                        asm_d = asm_ins;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            words_q <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader against a stream-level reference model.
// Checksum streams are produced when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_byte = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [15:0]       words_loaded;
    logic              busy;
    logic              done;
    logic              error;
    logic              core_rst_n;

    int checks = 0;
    int errors = 0;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .words_loaded (words_loaded),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .core_rst_n   (core_rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_rst_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_we"}, 32'(imem_we), 0);
        check({tag, "_addr"}, 32'(imem_addr), 0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_words"}, 32'(words_loaded), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 0);
    endtask

    function automatic int stream_len(input bq_t s);
        return int'(s[0]) | (int'(s[1]) << 8);
    endfunction

    // Random stream of n words; a bad checksum flips one bit of the sum.
    task automatic build(input int n, input bit bad, output bq_t s);
        logic [31:0] sum;
        logic [31:0] w;
        sum = 0;
        s = {};
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        if (n <= DEPTH) begin
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                sum = sum + w;
                for (int b = 0; b < 4; b++) s.push_back(8'(w >> (8 * b)));
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (n <= DEPTH) begin
            if (bad) sum = sum ^ (32'h1 << $urandom_range(31));
            for (int b = 0; b < 4; b++) s.push_back(8'(sum >> (8 * b)));
        end
`else
        if (bad) sum = 0;
`endif
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_start_busy"}, 32'(busy), 1);
        check({tag, "_start_core_rst_n"}, 32'(core_rst_n), 0);
        check({tag, "_start_words"}, 32'(words_loaded), 0);
    endtask

    // vpct < 0 toggles in_valid every other cycle.
    task automatic feed(input string tag, input bq_t s, input int limit,
                        input int vpct, input bit poke, output int nwr);
        int idx;
        int n;
        int cyc;
        int pk;
        bit pend;
        logic [31:0] pw;
        idx = 0;
        cyc = 0;
        pk = 0;
        pend = 0;
        pw = 0;
        nwr = 0;
        n = stream_len(s);
        while (idx < limit && cyc < 5000) begin
            if (vpct < 0) in_valid = (cyc % 2) == 0;
            else in_valid = $urandom_range(99) < vpct;
            in_byte = in_valid ? s[idx] : 8'($urandom);
            start = poke && ($urandom_range(7) == 0);
            @(negedge clk);
            check({tag, "_we"}, 32'(imem_we), 32'(pend));
            if (imem_we) begin
                nwr++;
                check({tag, "_addr"}, 32'(imem_addr), pk);
                check({tag, "_wdata"}, imem_wdata, pw);
            end
            pend = 0;
            if (in_valid && in_ready) begin
                if (idx >= 2 && n <= DEPTH && idx < 2 + 4 * n
                    && (idx - 2) % 4 == 3) begin
                    pend = 1;
                    pk = (idx - 2) / 4;
                    pw = {s[idx], s[idx-1], s[idx-2], s[idx-3]};
                end
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check({tag, "_bytes_taken"}, idx, limit);
        @(negedge clk);
        check({tag, "_we_tail"}, 32'(imem_we), 32'(pend));
        if (imem_we) begin
            nwr++;
            check({tag, "_addr_tail"}, 32'(imem_addr), pk);
            check({tag, "_wdata_tail"}, imem_wdata, pw);
        end
    endtask

    task automatic check_end(input string tag, input bq_t s, input int nwr);
        int n;
        bit ok;
        logic [31:0] sum;
        logic [31:0] rx;
        n = stream_len(s);
        ok = n <= DEPTH;
        sum = 0;
        if (ok) begin
            for (int k = 0; k < n; k++)
                sum = sum + {s[5+4*k], s[4+4*k], s[3+4*k], s[2+4*k]};
`ifdef IMEM_LOADER_CHECKSUM_EN
            rx = {s[5+4*n], s[4+4*n], s[3+4*n], s[2+4*n]};
            ok = (rx == sum);
`else
            rx = sum;
`endif
        end
        check({tag, "_nwrites"}, nwr, (n <= DEPTH) ? n : 0);
        check({tag, "_words"}, 32'(words_loaded), (n <= DEPTH) ? n : 0);
        check({tag, "_done"}, 32'(done), 32'(ok));
        check({tag, "_error"}, 32'(error), 32'(!ok));
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(ok));
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
    endtask

    initial begin
        bq_t s;
        bq_t s1;
        int nw;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_rst_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_rst_vals("idle");
        @(posedge clk);
        #1;

        s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'hBB);
        s.push_back(8'hDD);
        s.push_back(8'hFF);
        s.push_back(8'h21);
`endif
        do_start("dir");
        feed("dir", s, s.size(), 100, 0, nw);
        check_end("dir", s, nw);

        do_start("tog");
        feed("tog", s, s.size(), -1, 0, nw);
        check_end("tog", s, nw);

`ifdef IMEM_LOADER_CHECKSUM_EN
        s1 = s;
        s1[10] = 8'hBC;
        do_start("badsum");
        feed("badsum", s1, s1.size(), 100, 0, nw);
        check_end("badsum", s1, nw);
`endif

        s = '{8'h41, 8'h00};
        do_start("ovf");
        feed("ovf", s, s.size(), 100, 0, nw);
        check_end("ovf", s, nw);

        build(0, 0, s);
        do_start("zero");
        feed("zero", s, s.size(), 100, 0, nw);
        check_end("zero", s, nw);
        do_start("restart");

        build(2, 0, s);
        feed("abort", s, 8, 100, 0, nw);
        check("abort_nwrites", nw, 1);
        #2;
        rst = 1'b0;
        #1;
        check_rst_vals("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        build(1, 0, s1);
        do_start("after_rst");
        feed("after_rst", s1, s1.size(), 70, 0, nw);
        check_end("after_rst", s1, nw);

        for (int t = 0; t < 10; t++) begin
            if (t == 0) n = DEPTH;
            else if (t == 1) n = DEPTH + 1;
            else if (t == 2) n = 16'hFFFF;
            else n = $urandom_range(1, 20);
            build(n, (t % 3) == 2, s);
            do_start($sformatf("rnd%0d", t));
            feed($sformatf("rnd%0d", t), s, s.size(),
                 $urandom_range(30, 100), 1, nw);
            check_end($sformatf("rnd%0d", t), s, nw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
